key_debounce_fsm: RTL and testbench

- Downstream consumer of the edge detector's neg_flag/pos_flag pulses for an active-low DE2 push-button.
- Confirms a press or release only if the input stays stable for CNT_MAX clocks after an edge; otherwise the edge is treated as bounce.
- Produces a one-cycle key_flag per confirmed transition, a debounced key_state level, and a running count of confirmed presses for downstream control logic.

---
 rtl/key_debounce_fsm.sv | 114 +++++++++++
 tb/tb_key_debounce_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm
// Debounce FSM for an active-low push-button. It consumes the one-cycle
// neg_flag/pos_flag pulses from an upstream edge detector.
// A press or release is confirmed only after the key has stayed quiet for
// CNT_MAX clocks. When a transition is confirmed, the block raises
// key_flag for one cycle, updates the key_state level and counts presses.
module key_debounce_fsm #(
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20,
  parameter int PCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              neg_flag,
  input  logic              pos_flag,
  output logic              key_flag,
  output logic              key_state,
  output logic [PCNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                key_flag_reg, key_flag_next;
  logic                key_state_reg, key_state_next;
  logic [PCNT_W-1:0]   press_cnt_reg, press_cnt_next;

  // The edge detector never asserts both flags at once. If it ever does,
  // the pair is treated as no event at all.
  logic neg_only;
  logic pos_only;
  assign neg_only = neg_flag & ~pos_flag;
  assign pos_only = pos_flag & ~neg_flag;

  // State and output registers. Reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      key_flag_reg  <= 1'b0;
      key_state_reg <= 1'b1;
      press_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      key_flag_reg  <= key_flag_next;
      key_state_reg <= key_state_next;
      press_cnt_reg <= press_cnt_next;
    end
  end

  // Next-state logic. cnt defaults to 0, so it only runs inside the filter
  // states. In those states, an opposing flag takes priority over terminal count.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = '0;
    key_flag_next  = 1'b0;
    key_state_next = key_state_reg;
    press_cnt_next = press_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (neg_only) state_next = FILTER_DOWN;
      end
      FILTER_DOWN: begin
        if (pos_only) begin
          state_next = IDLE;                 // bounce, back to released
        end else if (neg_only) begin
          cnt_next = '0;                     // fresh falling edge restarts window
        end else if (cnt_reg == CNT_LAST) begin
          state_next     = DOWN;
          key_flag_next  = 1'b1;
          key_state_next = 1'b0;
          press_cnt_next = press_cnt_reg + PCNT_ONE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DOWN: begin
        if (pos_only) state_next = FILTER_UP;
      end
      FILTER_UP: begin
        if (neg_only) begin
          state_next = DOWN;                 // bounce, back to pressed
        end else if (pos_only) begin
          cnt_next = '0;                     // fresh rising edge restarts window
        end else if (cnt_reg == CNT_LAST) begin
          state_next     = IDLE;
          key_flag_next  = 1'b1;
          key_state_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign key_flag  = key_flag_reg;
  assign key_state = key_state_reg;
  assign press_cnt = press_cnt_reg;

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Self-checking bench for key_debounce_fsm with CNT_MAX = 10.
// It has three parts:
//   - a table of directed vectors,
//   - hand-written reset and wrap sequences,
//   - randomized flags checked against a reference model.
// The model tracks the age of the pending edge relative to the stable level.
module tb_key_debounce_fsm;

  localparam int CNT_MAX = 10;
  localparam int CNT_W   = 4;
  localparam int PCNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              neg_flag;
  logic              pos_flag;
  logic              key_flag;
  logic              key_state;
  logic [PCNT_W-1:0] press_cnt;

  int checks = 0;
  int errors = 0;

  key_debounce_fsm #(
    .CNT_MAX(CNT_MAX),
    .CNT_W  (CNT_W),
    .PCNT_W (PCNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .neg_flag (neg_flag),
    .pos_flag (pos_flag),
    .key_flag (key_flag),
    .key_state(key_state),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       n;
    logic       p;
    logic       f;
    logic       s;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic n, input logic p, input logic f, input logic s,
                     input logic [7:0] c);
    vec_t v;
    v.n = n; v.p = p; v.f = f; v.s = s; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic add_quiet(input int len, input logic s, input logic [7:0] c);
    for (int k = 0; k < len; k++) add(1'b0, 1'b0, 1'b0, s, c);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs and returns #1 after the sampling edge.
  task automatic cycle(input logic n, input logic p);
    neg_flag = n;
    pos_flag = p;
    @(posedge clk);
    #1;
  endtask

  // Reference model state.
  logic m_level;    // 1 = released
  logic m_pending;
  int   m_age;
  int   m_presses;
  logic m_flag;

  task automatic model_reset();
    m_level = 1'b1; m_pending = 1'b0; m_age = 0; m_presses = 0; m_flag = 1'b0;
  endtask

  task automatic model_step(input logic n, input logic p);
    logic toward, away;
    // toward: an edge leaving the stable level. away: an edge returning to it.
    toward = m_level ? (n & ~p) : (p & ~n);
    away   = m_level ? (p & ~n) : (n & ~p);
    m_flag = 1'b0;
    if (!m_pending) begin
      if (toward) begin
        m_pending = 1'b1;
        m_age = 0;
      end
    end else if (away) begin
      m_pending = 1'b0;
    end else if (toward) begin
      m_age = 0;
    end else if (m_age == CNT_MAX - 1) begin
      m_pending = 1'b0;
      m_flag = 1'b1;
      if (m_level) m_presses++;
      m_level = ~m_level;
    end else begin
      m_age++;
    end
  endtask

  initial begin
    int flags;
    logic prev_flag;
    int r;
    logic rn, rp;

    neg_flag = 1'b0;
    pos_flag = 1'b0;
    rst_n    = 1'b0;

    // Outputs while reset is held.
    #100;
    check("rst_key_flag",  key_flag,  0);
    check("rst_key_state", key_state, 1);
    check("rst_press_cnt", press_cnt, 0);
    #100;
    rst_n = 1'b1;   // t = 200, on a falling clock edge

    // Directed timeline. Each entry gives the inputs for cycle k
    // and the outputs expected in cycle k+1.
    // Clean press: neg at 0, flag in cycle 11.
    add(1, 0, 0, 1, 0);
    add_quiet(9, 1, 0);
    add(0, 0, 1, 0, 1);
    add_quiet(19, 0, 1);
    // Clean release: pos at cycle 30, flag in cycle 41.
    add(0, 1, 0, 0, 1);
    add_quiet(9, 0, 1);
    add(0, 0, 1, 1, 1);
    add_quiet(2, 1, 1);
    // Bounced press: neg at 0, pos at 4, neg at 6, flag in cycle 17.
    add(1, 0, 0, 1, 1);
    add_quiet(3, 1, 1);
    add(0, 1, 0, 1, 1);
    add_quiet(1, 1, 1);
    add(1, 0, 0, 1, 1);
    add_quiet(9, 1, 1);
    add(0, 0, 1, 0, 2);
    add_quiet(2, 0, 2);
    // Clean release back to IDLE.
    add(0, 1, 0, 0, 2);
    add_quiet(9, 0, 2);
    add(0, 0, 1, 1, 2);
    add_quiet(2, 1, 2);
    // Collision in the terminal-count cycle: neg at 0, pos at 10, no flag.
    add(1, 0, 0, 1, 2);
    add_quiet(9, 1, 2);
    add(0, 1, 0, 1, 2);
    add_quiet(14, 1, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].n, tbl[i].p);
      check($sformatf("vec%0d_key_flag", i),  key_flag,  tbl[i].f);
      check($sformatf("vec%0d_key_state", i), key_state, tbl[i].s);
      check($sformatf("vec%0d_press_cnt", i), press_cnt, tbl[i].c);
    end

    // Reset in the middle of FILTER_DOWN drops the pending press.
    cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    #5 rst_n = 1'b0;
    #1;
    check("midrst_key_flag",  key_flag,  0);
    check("midrst_key_state", key_state, 1);
    check("midrst_press_cnt", press_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    flags = 0;
    for (int k = 0; k < 15; k++) begin
      cycle(1'b0, 1'b0);
      if (key_flag) flags++;
      if (key_state != 1'b1) flags++;
    end
    check("midrst_no_flag", flags, 0);

    // 256 confirmed presses: press_cnt wraps back to 0.
    flags = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 11; k++) begin
        cycle(1'b0, 1'b0);
        if (key_flag) flags++;
      end
      if (i == 254) check("wrap_cnt_255", press_cnt, 255);
      cycle(1'b0, 1'b1);
      for (int k = 0; k < 11; k++) begin
        cycle(1'b0, 1'b0);
        if (key_flag) flags++;
      end
    end
    check("wrap_flags", flags, 512);
    check("wrap_press_cnt", press_cnt, 0);
    check("wrap_key_state", key_state, 1);

    // Random flags compared against the model every cycle.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    prev_flag = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      rn = (r < 4) || (r == 8);
      rp = (r >= 4 && r < 8) || (r == 8);
      model_step(rn, rp);
      cycle(rn, rp);
      check($sformatf("rnd%0d_key_flag", i),  key_flag,  m_flag);
      check($sformatf("rnd%0d_key_state", i), key_state, m_level);
      check($sformatf("rnd%0d_press_cnt", i), press_cnt, m_presses % 256);
      if (prev_flag && key_flag) begin
        check($sformatf("rnd%0d_flag_double", i), 1, 0);
      end
      prev_flag = key_flag;
    end
    check("rnd_presses_seen", press_cnt, m_presses % 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
